// File: rtl/dmem_dump_pkg.sv
// Shared definitions for the DMEM dump engine: FSM state encoding and word size.
// The optional checksum is enabled with the DMEM_DUMP_CHECKSUM_EN macro.
package dmem_dump_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } dump_state_e;

    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/dmem_dump_csum.sv
// Modulo-2^32 running sum of every word accepted on the output stream.
// Only instantiated when DMEM_DUMP_CHECKSUM_EN is defined.
module dmem_dump_csum (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        add_en,
    input  logic [0:31] data,
    output logic [0:31] sum
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/dmem_dump_engine.sv
// Streams word_count consecutive DMEM words out over a valid/ready interface.
// Optional out_checksum port is added when DMEM_DUMP_CHECKSUM_EN is defined.
module dmem_dump_engine
    import dmem_dump_pkg::*;
#(
    parameter int COUNT_W   = 16,
    parameter int MAX_STALL = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [0:31]        base_addr,
    input  logic [COUNT_W-1:0] word_count,
    output logic               busy,
    output logic               done,
    output logic [0:31]        addr_to_mem,
    output logic               write_enable_to_mem,
    output logic               byte_to_mem,
    output logic               half_word_to_mem,
    output logic               sign_extend_to_mem,
    input  logic [0:31]        data_from_mem,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:31]        out_data,
    output logic [0:31]        out_addr,
    output logic               out_last,
    output logic               stall_err,
`ifdef DMEM_DUMP_CHECKSUM_EN
    output logic [0:31]        out_checksum,
`endif
    output dump_state_e        state_dbg
);

    // Stream handshake: a beat transfers on a rising edge where out_valid and
    // out_ready are both high; while out_valid waits, out_data/out_addr/out_last
    // stay frozen.
    dump_state_e        state, state_next;
    logic [0:31]        cur_addr;
    logic [COUNT_W-1:0] remaining;
    logic [15:0]        stall_cnt;
    logic               transfer;
    logic               stall_cycle;
    logic               start_accept;
    logic               unused_addr_bits;

    assign transfer         = out_valid & out_ready;
    assign stall_cycle      = out_valid & ~out_ready;
    assign start_accept     = (state == IDLE) & start;
    assign unused_addr_bits = ^base_addr[30:31];

    assign addr_to_mem         = cur_addr;
    assign write_enable_to_mem = 1'b0;
    assign byte_to_mem         = 1'b0;
    assign half_word_to_mem    = 1'b0;
    assign sign_extend_to_mem  = 1'b0;
    assign state_dbg           = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (word_count == '0) ? DONE : FETCH;
            FETCH:   state_next = HOLD;
            HOLD:    if (out_ready) state_next = (remaining == COUNT_W'(1)) ? DONE : FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == FETCH) || (state == HOLD);
        done      = (state == DONE);
        out_valid = (state == HOLD);
        out_last  = (state == HOLD) && (remaining == COUNT_W'(1));
    end

    // Address/count datapath; the byte offset of base_addr is discarded.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_addr  <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && word_count != '0) begin
                        cur_addr  <= {base_addr[0:29], 2'b00};
                        remaining <= word_count;
                    end
                end
                FETCH: begin
                    out_data <= data_from_mem;
                    out_addr <= cur_addr;
                end
                HOLD: begin
                    if (out_ready) begin
                        remaining <= remaining - COUNT_W'(1);
                        if (remaining != COUNT_W'(1)) cur_addr <= cur_addr + WORD_BYTES;
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating stall counter; stall_err is sticky until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else begin
            if (transfer) begin
                stall_cnt <= '0;
            end else if (stall_cycle && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (MAX_STALL != 0 && stall_cycle && (32'(stall_cnt) + 32'd1 >= 32'(MAX_STALL))) begin
                stall_err <= 1'b1;
            end
        end
    end

`ifdef DMEM_DUMP_CHECKSUM_EN
    dmem_dump_csum u_csum (
        .clock  (clock),
        .reset  (reset),
        .clear  (start_accept),
        .add_en (transfer),
        .data   (out_data),
        .sum    (out_checksum)
    );
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_dmem_dump_engine.sv
// Directed bench for dmem_dump_engine; checks out_checksum when DMEM_DUMP_CHECKSUM_EN is defined.
module tb_dmem_dump_engine;
    import dmem_dump_pkg::*;

    logic        clock;
    logic        reset;
    logic        start;
    logic [0:31] base_addr;
    logic [15:0] word_count;
    logic        busy, done;
    logic [0:31] addr_to_mem;
    logic        write_enable_to_mem, byte_to_mem, half_word_to_mem, sign_extend_to_mem;
    logic [0:31] data_from_mem;
    logic        out_valid, out_ready;
    logic [0:31] out_data, out_addr;
    logic        out_last, stall_err;
`ifdef DMEM_DUMP_CHECKSUM_EN
    logic [0:31] out_checksum;
`endif
    dump_state_e state_dbg;

    int checks = 0;
    int errors = 0;
    logic ctrl_bad = 1'b0;
    logic [31:0] exp_q[$];

    dmem_dump_engine #(.COUNT_W(16), .MAX_STALL(3)) dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
        .base_addr           (base_addr),
        .word_count          (word_count),
        .busy                (busy),
        .done                (done),
        .addr_to_mem         (addr_to_mem),
        .write_enable_to_mem (write_enable_to_mem),
        .byte_to_mem         (byte_to_mem),
        .half_word_to_mem    (half_word_to_mem),
        .sign_extend_to_mem  (sign_extend_to_mem),
        .data_from_mem       (data_from_mem),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_addr            (out_addr),
        .out_last            (out_last),
        .stall_err           (stall_err),
`ifdef DMEM_DUMP_CHECKSUM_EN
        .out_checksum        (out_checksum),
`endif
        .state_dbg           (state_dbg)
    );

    // Clock/reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // DMEM model: words 1..4 at 8192..8207, address-derived pattern elsewhere.
    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a >= 32'd8192 && a <= 32'd8207) return ((a - 32'd8192) >> 2) + 32'd1;
        return a ^ 32'hDEAD_0000;
    endfunction
    assign data_from_mem = mem_read(addr_to_mem);

    always @(negedge clock) begin
        if (write_enable_to_mem | byte_to_mem | half_word_to_mem | sign_extend_to_mem) ctrl_bad = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Driver tasks
    task automatic start_dump(input logic [31:0] base, input logic [15:0] cnt);
        start      = 1'b1;
        base_addr  = base;
        word_count = cnt;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Waits (bounded) for out_valid, checks the beat against exp_q, then lets it transfer.
    task automatic wait_beat(input string tag, input logic [31:0] ea, input logic el);
        int n = 0;
        logic [31:0] ed;
        while (!out_valid && n < 10) begin
            @(negedge clock);
            n++;
        end
        check({tag, " valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, " addr"}, out_addr, ea);
        check({tag, " last"}, {31'd0, out_last}, {31'd0, el});
        if (exp_q.size() == 0) begin
            check({tag, " queue"}, 32'd1, 32'd0);
        end else begin
            ed = exp_q.pop_front();
            check({tag, " data"}, out_data, ed);
        end
        @(negedge clock);
    endtask

    task automatic check_done(input string tag);
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " q_empty"}, exp_q.size(), 32'd0);
        @(negedge clock);
        check({tag, " done_drop"}, {31'd0, done}, 32'd0);
        check({tag, " idle"}, {30'd0, state_dbg}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        out_ready  = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst valid", {31'd0, out_valid}, 32'd0);
        check("rst addr_to_mem", addr_to_mem, 32'd0);
        check("rst out_data", out_data, 32'd0);
        check("rst stall_err", {31'd0, stall_err}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Basic 4-word dump, always ready
        exp_q = {32'd1, 32'd2, 32'd3, 32'd4};
        start_dump(32'd8192, 16'd4);
        check("t1 busy", {31'd0, busy}, 32'd1);
        check("t1 fetch valid", {31'd0, out_valid}, 32'd0);
        check("t1 addr_to_mem", addr_to_mem, 32'd8192);
        wait_beat("t1 b0", 32'd8192, 1'b0);
        wait_beat("t1 b1", 32'd8196, 1'b0);
        wait_beat("t1 b2", 32'd8200, 1'b0);
        wait_beat("t1 b3", 32'd8204, 1'b1);
`ifdef DMEM_DUMP_CHECKSUM_EN
        check("t1 checksum", out_checksum, 32'd10);
`endif
        check("t1 stall_err", {31'd0, stall_err}, 32'd0);
        check_done("t1");

        // Same dump with beat 2 stalled for 5 cycles
        exp_q = {32'd1, 32'd2, 32'd3, 32'd4};
        start_dump(32'd8192, 16'd4);
        wait_beat("t2 b0", 32'd8192, 1'b0);
        out_ready = 1'b0;
        @(negedge clock);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            check("t2 hold valid", {31'd0, out_valid}, 32'd1);
            check("t2 hold data", out_data, 32'd2);
            check("t2 hold addr", out_addr, 32'd8196);
            if (k == 2) check("t2 stall_err early", {31'd0, stall_err}, 32'd0);
            if (k == 3) check("t2 stall_err set", {31'd0, stall_err}, 32'd1);
        end
        out_ready = 1'b1;
        wait_beat("t2 b1", 32'd8196, 1'b0);
        wait_beat("t2 b2", 32'd8200, 1'b0);
        wait_beat("t2 b3", 32'd8204, 1'b1);
`ifdef DMEM_DUMP_CHECKSUM_EN
        check("t2 checksum", out_checksum, 32'd10);
`endif
        check_done("t2");
        check("t2 stall_err sticky", {31'd0, stall_err}, 32'd1);

        // Zero-length dump
        start_dump(32'h0000_0040, 16'd0);
        check("t3 done", {31'd0, done}, 32'd1);
        check("t3 busy", {31'd0, busy}, 32'd0);
        check("t3 valid", {31'd0, out_valid}, 32'd0);
        @(negedge clock);
        check("t3 done_drop", {31'd0, done}, 32'd0);
        check("t3 valid after", {31'd0, out_valid}, 32'd0);

        // Unaligned base at top of address space wraps to 0
        exp_q = {32'h2152_FFFC, 32'hDEAD_0000};
        start_dump(32'hFFFF_FFFE, 16'd2);
        check("t4 addr_to_mem", addr_to_mem, 32'hFFFF_FFFC);
        wait_beat("t4 b0", 32'hFFFF_FFFC, 1'b0);
        wait_beat("t4 b1", 32'h0000_0000, 1'b1);
`ifdef DMEM_DUMP_CHECKSUM_EN
        check("t4 checksum", out_checksum, 32'h0000_FFFC);
`endif
        check_done("t4");

        // Start while busy is ignored
        exp_q = {32'd1, 32'd2, 32'd3, 32'd4};
        start_dump(32'd8192, 16'd4);
        wait_beat("t5 b0", 32'd8192, 1'b0);
        start      = 1'b1;
        base_addr  = 32'h0000_0300;
        word_count = 16'd1;
        wait_beat("t5 b1", 32'd8196, 1'b0);
        start = 1'b0;
        wait_beat("t5 b2", 32'd8200, 1'b0);
        wait_beat("t5 b3", 32'd8204, 1'b1);
`ifdef DMEM_DUMP_CHECKSUM_EN
        check("t5 checksum", out_checksum, 32'd10);
`endif
        check_done("t5");

        // Reset in the middle of beat 2
        exp_q = {32'd1};
        start_dump(32'd8192, 16'd4);
        wait_beat("t6 b0", 32'd8192, 1'b0);
        @(negedge clock);
        check("t6 pre-reset valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("t6 rst valid", {31'd0, out_valid}, 32'd0);
        check("t6 rst busy", {31'd0, busy}, 32'd0);
        check("t6 rst out_data", out_data, 32'd0);
        check("t6 rst out_addr", out_addr, 32'd0);
        check("t6 rst addr_to_mem", addr_to_mem, 32'd0);
        check("t6 rst stall_err", {31'd0, stall_err}, 32'd0);
        check("t6 rst last", {31'd0, out_last}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        exp_q = {32'hDEAD_0100, 32'hDEAD_0104};
        start_dump(32'h0000_0100, 16'd2);
        wait_beat("t6 b0", 32'h0000_0100, 1'b0);
        wait_beat("t6 b1", 32'h0000_0104, 1'b1);
`ifdef DMEM_DUMP_CHECKSUM_EN
        check("t6 checksum", out_checksum, 32'hBD5A_0204);
`endif
        check_done("t6");

        check("write_enable never high", {31'd0, ctrl_bad}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_dump_engine.md
DMEM_DUMP_ENGINE -- requirements
Module: dmem_dump_engine

Interface
REQ-001 Parameter COUNT_W, default 16: width of the word-count input.
REQ-002 Parameter MAX_STALL, default 0: cycles out_valid may stay unaccepted before stall_err sets; 0 disables the check.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a dump; sampled in IDLE only.
REQ-006 base_addr  input  [0:31]  first byte address; bits [30:31] ignored, word-aligned.
REQ-007 word_count  input  [COUNT_W-1:0]  number of 32-bit words to read.
REQ-008 busy  output  1  high from accepted start until done.
REQ-009 done  output  1  one-cycle pulse at end of dump.
REQ-010 addr_to_mem  output  [0:31]  DMEM address.
REQ-011 write_enable_to_mem, byte_to_mem, half_word_to_mem, sign_extend_to_mem  output  1 each  always 0 (word reads only).
REQ-012 data_from_mem  input  [0:31]  DMEM combinational read data, valid in the same cycle as addr_to_mem.
REQ-013 out_valid / out_ready  output / input  1  stream handshake; transfer when both are high on a rising edge.
REQ-014 out_data, out_addr  output  [0:31]  word read, and the byte address it was read from.
REQ-015 out_last  output  1  high with the final word of the dump.
REQ-016 stall_err  output  1  sticky; sets when the stall limit is exceeded.

Function
REQ-017 FSM states IDLE, FETCH, HOLD, DONE.
REQ-018 IDLE, start=1, word_count!=0: latch aligned base_addr and word_count; busy=1; go to FETCH.
REQ-019 IDLE, start=1, word_count=0: go to DONE; no DMEM access and no stream beat.
REQ-020 FETCH: drive addr_to_mem=cur_addr; register data_from_mem into out_data and cur_addr into out_addr; set out_valid; go to HOLD. Address-to-valid latency is 1 cycle.
REQ-021 HOLD: out_valid, out_data, out_addr and out_last are held stable until out_ready=1.
REQ-022 HOLD, transfer, remaining>1: cur_addr+=4 (modulo 2^32, wraps from 0xFFFFFFFC to 0); remaining-=1; drop out_valid; go to FETCH. Peak throughput is one word per 2 cycles.
REQ-023 HOLD, transfer, remaining=1: go to DONE.
REQ-024 out_last = out_valid AND remaining=1.
REQ-025 DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
REQ-026 start while busy is ignored; base_addr and word_count are not re-sampled.
REQ-027 addr_to_mem = cur_addr in every state.
REQ-028 Stall counter counts cycles with out_valid=1 and out_ready=0, and clears on transfer. When MAX_STALL!=0 and the count reaches MAX_STALL, stall_err sets. Stall does not abort the dump. stall_err clears only on reset.

Reset
REQ-029 Reset at any time, including mid-dump or mid-HOLD, forces IDLE asynchronously. The in-flight word is dropped.
REQ-030 Reset values: all outputs 0; cur_addr, remaining and the stall counter are 0.

Configuration
REQ-031 Macro DMEM_DUMP_CHECKSUM_EN defined: adds output out_checksum [0:31], the modulo-2^32 sum of all transferred out_data. It clears on accepted start and is valid when done=1.
REQ-032 Macro undefined: no out_checksum port and no adder logic. All other behaviour is identical.

Structure
REQ-033 Package dmem_dump_pkg holds the state encoding (IDLE=0, FETCH=1, HOLD=2, DONE=3) and the constant WORD_BYTES=4.
REQ-034 Sub-module dmem_dump_csum contains the checksum accumulator and is instantiated only under DMEM_DUMP_CHECKSUM_EN. All other logic lives in dmem_dump_engine.

Verification
REQ-035 DMEM[8192..8207] holds words 1,2,3,4; start, base=8192, count=4, out_ready=1 -> four beats with addr 8192/8196/8200/8204, data 1..4, out_last on the 4th, done one cycle later, out_checksum=10 with macro.
REQ-036 Same dump with out_ready low for 5 cycles on beat 2 -> data and addr held stable throughout, no beat lost or duplicated; MAX_STALL=3 -> stall_err=1 and stays 1.
REQ-037 start, count=0 -> done one cycle later, out_valid never high, busy stays 0.
REQ-038 base=0xFFFFFFFE, count=2 -> beats at addr 0xFFFFFFFC then 0x00000000.
REQ-039 Reset asserted during beat 2 of a 4-word dump -> all outputs 0 immediately, next start runs from the new base with no stale beat.
REQ-040 start pulsed again while busy with a different base -> original dump completes unchanged; write_enable_to_mem is 0 on every cycle.
